mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-stage controller that consumes the EX/MEM pipeline register outputs, performs data-memory loads and stores over a req/ack data bus, and formats load data for the MEM/WB register. It also resolves the conditional branch recorded in EX/MEM. While a bus transaction is outstanding it holds `mem_stall` high toward the control unit, which feeds `cu_stall`.

## Interface
Parameters:
- `ADDR_W`, default 32: data-bus address width.

Ports (clock is `clk`; reset is `reset`, synchronous and active-high):
- `clk` in 1: clock; FSM updates on posedge.
- `reset` in 1: synchronous active-high reset.
- `mem_nop` in 1: the instruction in MEM is a bubble; no access and no branch.
- `exmem_mem_r` in 1: load.
- `exmem_mem_w` in 1: store.
- `exmem_alu_res` in 32: effective address.
- `exmem_aligned_rt_data` in 32: store data, already lane-aligned.
- `mem_byte_w_en` in 4: store byte lanes.
- `exmem_load_sel` in 3: load type.
- `exmem_branch` in 1: branch instruction.
- `exmem_condition` in 3: branch condition.
- `exmem_lf`, `exmem_zf` in 1 each: ALU less/zero flags.
- `exmem_target` in 32: branch target.
- `dbus_req` out 1: bus request.
- `dbus_we` out 1: write.
- `dbus_addr` out ADDR_W: word address; bits [1:0] forced to 0.
- `dbus_wdata` out 32: write data.
- `dbus_be` out 4: byte enables.
- `dbus_ack` in 1: transfer complete, one-cycle pulse.
- `dbus_err` in 1: bus error, qualified by `dbus_ack`.
- `dbus_rdata` in 32: read word, valid with `dbus_ack`.
- `mem_stall` out 1: hold the pipeline.
- `mem_load_data` out 32: formatted load result.
- `mem_load_valid` out 1: `mem_load_data` is valid for this instruction.
- `branch_taken` out 1: redirect request.
- `branch_target` out 32: redirect PC.
- `mem_addr_err` out 1: misaligned load.
- `mem_bus_err` out 1: bus error on the completed access.

## Operation
- Access is requested when `!mem_nop && (exmem_mem_r || exmem_mem_w)` and the access is aligned.
- Load encodings:
  - 0: LW
  - 1: LB
  - 2: LBU
  - 3: LH
  - 4: LHU
  - 5–7: treated as LW.
- Alignment rules:
  - LW requires `addr[1:0]==0`.
  - LH/LHU require `addr[0]==0`.
  - Stores are never flagged; `mem_byte_w_en` passes through as `dbus_be`.
- A misaligned load raises `mem_addr_err` combinationally, issues no request, does not stall, and keeps `mem_load_valid` at 0.
- FSM states:
  - IDLE: `mem_stall` = access requested. If an access is requested, latch addr/we/wdata/be/load_sel and go to BUSY.
  - BUSY: `dbus_req`=1 and `mem_stall`=1. All bus outputs stay stable until `dbus_ack`. On ack, register the formatted rdata and `dbus_err`, then go to DONE.
  - DONE: `mem_stall`=0 and `mem_load_valid`=`exmem_mem_r` of the latched access. `mem_bus_err` is valid. Go to IDLE unconditionally.
- Load formatting:
  - Select byte lane by `addr[1:0]` or half lane by `addr[1]` (little-endian).
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
- Branch conditions (combinational, gated by `exmem_branch && !mem_nop`):
  - 0: never
  - 1: `zf`
  - 2: `!zf`
  - 3: `lf`
  - 4: `!lf`
  - 5: `lf|zf`
  - 6: `!lf&!zf`
  - 7: always
- `branch_target` = `exmem_target` at all times.
- Branch resolution does not depend on the FSM.

## Timing
- Reset values:
  - state: IDLE
  - `dbus_req`, `dbus_we`: 0
  - `dbus_addr`, `dbus_wdata`, `dbus_be`: 0
  - `mem_load_data`: 0
  - `mem_load_valid`, `mem_bus_err`: 0
  - `mem_stall`: 0, because it is derived from IDLE; it is 1 only if a request is present.
- Latency: with ack in the first BUSY cycle, `mem_stall` is high for 2 cycles (IDLE detect plus BUSY) and DONE follows on the 3rd. Each wait cycle adds 1.
- `dbus_ack` seen in IDLE or DONE is ignored.
- Reset in BUSY returns the FSM to IDLE and drops `dbus_req` on the next edge. A later stray ack is ignored.
- In DONE the EX/MEM register advances at the following negedge, so the next posedge sees the new instruction in IDLE. Back-to-back accesses therefore cost at least 3 cycles each.
- A bubble (`mem_nop`=1) in IDLE never starts a transaction, regardless of `mem_r`/`mem_w`.

## Structure
- `mem_pkg`: load_sel encodings, condition encodings, FSM state enum (IDLE/BUSY/DONE).
- Sub-module `load_formatter`: combinational; inputs rdata, addr[1:0], load_sel; output 32-bit result. It is reused by the WB forwarding path.

## Test plan
- LW at 0x100 with ack after 2 wait cycles, rdata=0xDEADBEEF → `dbus_addr`=0x100, `mem_stall` high 4 cycles, DONE gives `mem_load_data`=0xDEADBEEF and `mem_load_valid`=1.
- LB at 0x103, rdata=0x80112233 → 0xFFFFFF80; LBU → 0x00000080; LH at 0x102 → 0xFFFF8011.
- SW with be=0b1100, wdata=0xABCD0000, addr 0x206 → `dbus_addr`=0x204, `dbus_we`=1, `dbus_be`=0xC; no `mem_load_valid`.
- LW at 0x101 → `mem_addr_err`=1, `dbus_req` never asserted, `mem_stall`=0.
- Branch: cond=1 with zf=1 → taken; cond=6 with lf=0, zf=0 → taken; any cond with `mem_nop`=1 → not taken.
- Reset asserted in BUSY, then ack arrives 1 cycle later → IDLE, `dbus_req`=0, `mem_load_valid` stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: load types, branch conditions and
// the access FSM state codes.
package mem_pkg;

  localparam logic [2:0] LS_LW  = 3'd0;
  localparam logic [2:0] LS_LB  = 3'd1;
  localparam logic [2:0] LS_LBU = 3'd2;
  localparam logic [2:0] LS_LH  = 3'd3;
  localparam logic [2:0] LS_LHU = 3'd4;

  localparam logic [2:0] BC_NEVER  = 3'd0;
  localparam logic [2:0] BC_EQ     = 3'd1;
  localparam logic [2:0] BC_NE     = 3'd2;
  localparam logic [2:0] BC_LT     = 3'd3;
  localparam logic [2:0] BC_GE     = 3'd4;
  localparam logic [2:0] BC_LE     = 3'd5;
  localparam logic [2:0] BC_GT     = 3'd6;
  localparam logic [2:0] BC_ALWAYS = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte/half of a little-endian read word.
// Purely combinational so the WB forwarding path can share it.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_sel,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (load_sel)
      LS_LB:   result = {{24{byte_v[7]}}, byte_v};
      LS_LBU:  result = {24'd0, byte_v};
      LS_LH:   result = {{16{half_v[15]}}, half_v};
      LS_LHU:  result = {16'd0, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: runs one req/ack data-bus transfer per load/store, stalls the
// pipeline while it is outstanding, and resolves the EX/MEM conditional branch.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_nop,
  input  logic              exmem_mem_r,
  input  logic              exmem_mem_w,
  input  logic [31:0]       exmem_alu_res,
  input  logic [31:0]       exmem_aligned_rt_data,
  input  logic [3:0]        mem_byte_w_en,
  input  logic [2:0]        exmem_load_sel,
  input  logic              exmem_branch,
  input  logic [2:0]        exmem_condition,
  input  logic              exmem_lf,
  input  logic              exmem_zf,
  input  logic [31:0]       exmem_target,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [31:0]       dbus_wdata,
  output logic [3:0]        dbus_be,
  input  logic              dbus_ack,
  input  logic              dbus_err,
  input  logic [31:0]       dbus_rdata,
  output logic              mem_stall,
  output logic [31:0]       mem_load_data,
  output logic              mem_load_valid,
  output logic              branch_taken,
  output logic [31:0]       branch_target,
  output logic              mem_addr_err,
  output logic              mem_bus_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        sel_q, sel_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              bus_err_q, bus_err_d;

  logic              is_word, is_half, misaligned, access_req;
  logic [31:0]       fmt_result;
  logic              cond_ok;

  // Encodings 5-7 fall back to a full-word load, so they need word alignment.
  always_comb begin
    is_half    = (exmem_load_sel == LS_LH) || (exmem_load_sel == LS_LHU);
    is_word    = !is_half && (exmem_load_sel != LS_LB) && (exmem_load_sel != LS_LBU);
    misaligned = !mem_nop && exmem_mem_r &&
                 ((is_word && (exmem_alu_res[1:0] != 2'b00)) || (is_half && exmem_alu_res[0]));
    access_req = !mem_nop && (exmem_mem_r || exmem_mem_w) && !misaligned;
  end

  load_formatter u_fmt (
    .rdata    (dbus_rdata),
    .addr_lo  (lane_q),
    .load_sel (sel_q),
    .result   (fmt_result)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    sel_d       = sel_q;
    lane_d      = lane_q;
    load_data_d = load_data_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        if (access_req) begin
          addr_d  = {exmem_alu_res[ADDR_W-1:2], 2'b00};
          lane_d  = exmem_alu_res[1:0];
          we_d    = exmem_mem_w;
          rd_d    = exmem_mem_r;
          wdata_d = exmem_aligned_rt_data;
          be_d    = mem_byte_w_en;
          sel_d   = exmem_load_sel;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (dbus_ack) begin
          load_data_d = fmt_result;
          bus_err_d   = dbus_err;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      sel_q       <= '0;
      lane_q      <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      sel_q       <= sel_d;
      lane_q      <= lane_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    dbus_req       = (state_q == ST_BUSY);
    dbus_we        = dbus_req && we_q;
    dbus_addr      = addr_q;
    dbus_wdata     = wdata_q;
    dbus_be        = be_q;
    mem_stall      = dbus_req || ((state_q == ST_IDLE) && access_req);
    mem_load_data  = load_data_q;
    mem_load_valid = (state_q == ST_DONE) && rd_q;
    mem_bus_err    = (state_q == ST_DONE) && bus_err_q;
    mem_addr_err   = misaligned;
  end

  always_comb begin
    cond_ok = 1'b0;
    case (exmem_condition)
      BC_NEVER:  cond_ok = 1'b0;
      BC_EQ:     cond_ok = exmem_zf;
      BC_NE:     cond_ok = !exmem_zf;
      BC_LT:     cond_ok = exmem_lf;
      BC_GE:     cond_ok = !exmem_lf;
      BC_LE:     cond_ok = exmem_lf || exmem_zf;
      BC_GT:     cond_ok = !exmem_lf && !exmem_zf;
      BC_ALWAYS: cond_ok = 1'b1;
      default:   cond_ok = 1'b0;
    endcase
    branch_taken  = exmem_branch && !mem_nop && cond_ok;
    branch_target = exmem_target;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a bus responder per access and an
// expected-load queue drained when the stage reports load data.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_nop, exmem_mem_r, exmem_mem_w;
  logic [31:0] exmem_alu_res, exmem_aligned_rt_data;
  logic [3:0]  mem_byte_w_en;
  logic [2:0]  exmem_load_sel;
  logic        exmem_branch;
  logic [2:0]  exmem_condition;
  logic        exmem_lf, exmem_zf;
  logic [31:0] exmem_target;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack, dbus_err;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic [31:0] mem_load_data;
  logic        mem_load_valid, branch_taken;
  logic [31:0] branch_target;
  logic        mem_addr_err, mem_bus_err;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .mem_nop(mem_nop),
    .exmem_mem_r(exmem_mem_r), .exmem_mem_w(exmem_mem_w),
    .exmem_alu_res(exmem_alu_res), .exmem_aligned_rt_data(exmem_aligned_rt_data),
    .mem_byte_w_en(mem_byte_w_en), .exmem_load_sel(exmem_load_sel),
    .exmem_branch(exmem_branch), .exmem_condition(exmem_condition),
    .exmem_lf(exmem_lf), .exmem_zf(exmem_zf), .exmem_target(exmem_target),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_ack(dbus_ack),
    .dbus_err(dbus_err), .dbus_rdata(dbus_rdata), .mem_stall(mem_stall),
    .mem_load_data(mem_load_data), .mem_load_valid(mem_load_valid),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .mem_addr_err(mem_addr_err), .mem_bus_err(mem_bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_nop     = 1'b1;
    exmem_mem_r = 1'b0;
    exmem_mem_w = 1'b0;
  endtask

  // Drives one aligned access, answers it after 'waits' extra BUSY cycles and
  // checks the bus phase, stall length and DONE-cycle results.
  task automatic run_access(input logic r, input logic w, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be,
                            input logic [2:0] sel, input int waits,
                            input logic [31:0] rdata, input logic err,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data);
    int stall_cnt;
    mem_nop = 1'b0; exmem_mem_r = r; exmem_mem_w = w;
    exmem_alu_res = addr; exmem_aligned_rt_data = wd;
    mem_byte_w_en = be; exmem_load_sel = sel;
    if (r) exp_q.push_back(exp_data);
    #1;
    check("addr_err_aligned", mem_addr_err, 0);
    stall_cnt = mem_stall ? 1 : 0;
    for (int c = 0; c <= waits; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        check("req_busy", dbus_req, 1);
        check("bus_addr", dbus_addr, exp_addr);
        check("bus_we", dbus_we, w);
        if (w) begin
          check("bus_be", dbus_be, be);
          check("bus_wdata", dbus_wdata, wd);
        end
      end
      if (mem_stall) stall_cnt++;
      if (c == waits) begin
        dbus_ack = 1'b1; dbus_rdata = rdata; dbus_err = err;
      end
    end
    @(posedge clk); #1;
    dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = 32'h5A5A_5A5A;
    check("stall_done", mem_stall, 0);
    check("stall_cycles", stall_cnt, waits + 2);
    check("req_done", dbus_req, 0);
    check("bus_err", mem_bus_err, err);
    if (r) begin
      check("load_valid", mem_load_valid, 1);
      if (exp_q.size() == 0) check("exp_q_underflow", 1, 0);
      else check("load_data", mem_load_data, exp_q.pop_front());
    end else begin
      check("store_no_valid", mem_load_valid, 0);
    end
    idle_inputs();
    @(posedge clk); #1;
    check("back_idle_req", dbus_req, 0);
    check("back_idle_valid", mem_load_valid, 0);
  endtask

  task automatic misaligned(input logic [31:0] addr, input logic [2:0] sel);
    mem_nop = 1'b0; exmem_mem_r = 1'b1; exmem_mem_w = 1'b0;
    exmem_alu_res = addr; exmem_load_sel = sel;
    #1;
    check("mis_addr_err", mem_addr_err, 1);
    check("mis_stall", mem_stall, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("mis_no_req", dbus_req, 0);
      check("mis_no_valid", mem_load_valid, 0);
    end
    idle_inputs();
    #1;
  endtask

  task automatic br(input logic nop, input logic b, input logic [2:0] cond,
                    input logic lf, input logic zf, input logic exp);
    mem_nop = nop; exmem_branch = b; exmem_condition = cond;
    exmem_lf = lf; exmem_zf = zf; exmem_target = $urandom;
    #1;
    check($sformatf("branch_c%0d_n%0d_l%0d_z%0d", cond, nop, lf, zf), branch_taken, exp);
    check("branch_target", branch_target, exmem_target);
  endtask

  initial begin
    reset = 1'b1; idle_inputs();
    exmem_alu_res = '0; exmem_aligned_rt_data = '0; mem_byte_w_en = '0;
    exmem_load_sel = '0; exmem_branch = 1'b0; exmem_condition = '0;
    exmem_lf = 1'b0; exmem_zf = 1'b0; exmem_target = '0;
    dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_req", dbus_req, 0);
    check("rst_we", dbus_we, 0);
    check("rst_addr", dbus_addr, 0);
    check("rst_wdata", dbus_wdata, 0);
    check("rst_be", dbus_be, 0);
    check("rst_load_data", mem_load_data, 0);
    check("rst_valid", mem_load_valid, 0);
    check("rst_bus_err", mem_bus_err, 0);
    check("rst_stall", mem_stall, 0);

    run_access(1, 0, 32'h100, 0, 4'h0, 3'd0, 2, 32'hDEADBEEF, 0, 32'h100, 32'hDEADBEEF);
    run_access(1, 0, 32'h103, 0, 4'h0, 3'd1, 0, 32'h80112233, 0, 32'h100, 32'hFFFFFF80);
    run_access(1, 0, 32'h103, 0, 4'h0, 3'd2, 1, 32'h80112233, 0, 32'h100, 32'h00000080);
    run_access(1, 0, 32'h102, 0, 4'h0, 3'd3, 0, 32'h80112233, 0, 32'h100, 32'hFFFF8011);
    run_access(1, 0, 32'h102, 0, 4'h0, 3'd4, 0, 32'h80112233, 0, 32'h100, 32'h00008011);
    run_access(1, 0, 32'h101, 0, 4'h0, 3'd1, 0, 32'h80112233, 0, 32'h100, 32'h00000022);
    run_access(1, 0, 32'h100, 0, 4'h0, 3'd3, 0, 32'h7FFF8000, 0, 32'h100, 32'hFFFF8000);
    run_access(1, 0, 32'h104, 0, 4'h0, 3'd6, 3, 32'h12345678, 1, 32'h104, 32'h12345678);
    run_access(0, 1, 32'h206, 32'hABCD0000, 4'hC, 3'd0, 0, 32'h0, 0, 32'h204, 32'h0);
    run_access(0, 1, 32'h30B, 32'h11000000, 4'h8, 3'd0, 2, 32'h0, 1, 32'h308, 32'h0);

    misaligned(32'h101, 3'd0);
    misaligned(32'h103, 3'd3);
    misaligned(32'h102, 3'd7);

    // Bubble carrying a stale load must not start a transfer.
    mem_nop = 1'b1; exmem_mem_r = 1'b1; exmem_alu_res = 32'h400; exmem_load_sel = 3'd0;
    #1;
    check("nop_stall", mem_stall, 0);
    @(posedge clk); #1;
    check("nop_no_req", dbus_req, 0);
    idle_inputs();

    br(0, 1, 3'd1, 0, 1, 1);
    br(0, 1, 3'd1, 0, 0, 0);
    br(0, 1, 3'd2, 0, 0, 1);
    br(0, 1, 3'd3, 1, 0, 1);
    br(0, 1, 3'd4, 1, 0, 0);
    br(0, 1, 3'd5, 0, 1, 1);
    br(0, 1, 3'd6, 0, 0, 1);
    br(0, 1, 3'd6, 1, 0, 0);
    br(0, 1, 3'd7, 1, 1, 1);
    br(0, 1, 3'd0, 1, 1, 0);
    br(1, 1, 3'd7, 1, 1, 0);
    br(1, 1, 3'd1, 0, 1, 0);
    br(0, 0, 3'd7, 0, 0, 0);
    exmem_branch = 1'b0;
    idle_inputs();

    // Reset while BUSY, then a stray ack.
    mem_nop = 1'b0; exmem_mem_r = 1'b1; exmem_alu_res = 32'h300; exmem_load_sel = 3'd0;
    @(posedge clk); #1;
    check("rb_req_busy", dbus_req, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; idle_inputs();
    #1;
    check("rb_req_dropped", dbus_req, 0);
    check("rb_stall", mem_stall, 0);
    dbus_ack = 1'b1; dbus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    check("rb_no_req", dbus_req, 0);
    check("rb_no_valid", mem_load_valid, 0);
    check("rb_load_data", mem_load_data, 0);
    @(posedge clk); #1;
    check("rb_still_no_valid", mem_load_valid, 0);

    // Ack in IDLE with no access pending.
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    check("idle_ack_req", dbus_req, 0);
    check("idle_ack_valid", mem_load_valid, 0);
    check("idle_ack_data", mem_load_data, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
